// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment decoder: active-low glyph patterns
// {s6..s0}, the all-off blank pattern and the result-handshake state type.
package seg_pkg;

  localparam logic [6:0] GLYPH_0   = 7'h40;
  localparam logic [6:0] GLYPH_1   = 7'h79;
  localparam logic [6:0] GLYPH_2   = 7'h24;
  localparam logic [6:0] GLYPH_3   = 7'h30;
  localparam logic [6:0] GLYPH_4   = 7'h19;
  localparam logic [6:0] GLYPH_5   = 7'h12;
  localparam logic [6:0] GLYPH_6   = 7'h02;
  localparam logic [6:0] GLYPH_7   = 7'h78;
  localparam logic [6:0] GLYPH_8   = 7'h00;
  localparam logic [6:0] GLYPH_9   = 7'h18;
  localparam logic [6:0] GLYPH_A   = 7'h08;
  localparam logic [6:0] GLYPH_B   = 7'h03;
  localparam logic [6:0] GLYPH_C   = 7'h46;
  localparam logic [6:0] GLYPH_D   = 7'h21;
  localparam logic [6:0] GLYPH_E   = 7'h06;
  localparam logic [6:0] GLYPH_F   = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } seg_state_t;

endpackage

// File: rtl/seg_decoder_if.sv
// Segment input plus decoded-result valid/ready bus of the seven-segment decoder.
// The slave modport is the decoder side, the master modport the consumer side.
interface seg_decoder_if;
  logic [6:0] seg_in;
  logic [3:0] out_digit;
  logic       out_err;
  logic       out_blank;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;

  modport master (
    output seg_in, out_ready,
    input  out_digit, out_err, out_blank, out_valid, overrun
  );

  modport slave (
    input  seg_in, out_ready,
    output out_digit, out_err, out_blank, out_valid, overrun
  );
endinterface

// File: rtl/seg_lut.sv
// Combinational glyph lookup: maps an active-low segment pattern to its hex
// digit, flags the all-off blank pattern, and flags anything else as an error.
module seg_lut
  import seg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_digit,
  output logic       o_err,
  output logic       o_blank
);

  // Pattern decode; blank and illegal patterns report digit 0.
  always_comb begin
    o_digit = 4'h0;
    o_err   = 1'b0;
    o_blank = 1'b0;
    case (i_pattern)
      GLYPH_0:   o_digit = 4'h0;
      GLYPH_1:   o_digit = 4'h1;
      GLYPH_2:   o_digit = 4'h2;
      GLYPH_3:   o_digit = 4'h3;
      GLYPH_4:   o_digit = 4'h4;
      GLYPH_5:   o_digit = 4'h5;
      GLYPH_6:   o_digit = 4'h6;
      GLYPH_7:   o_digit = 4'h7;
      GLYPH_8:   o_digit = 4'h8;
      GLYPH_9:   o_digit = 4'h9;
      GLYPH_A:   o_digit = 4'hA;
      GLYPH_B:   o_digit = 4'hB;
      GLYPH_C:   o_digit = 4'hC;
      GLYPH_D:   o_digit = 4'hD;
      GLYPH_E:   o_digit = 4'hE;
      GLYPH_F:   o_digit = 4'hF;
      SEG_BLANK: o_blank = 1'b1;
      default:   o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_decoder.sv
// Seven-segment pattern decoder with stability filter and valid/ready result.
// Define SEG_DEC_SYNC_EN to put a 2-flop synchronizer in front of the filter.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  seg_decoder_if.slave  bus
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_ACC = 4'(STABLE_CYCLES - 2);

  logic [6:0] w_filt_in;

`ifdef SEG_DEC_SYNC_EN
  logic [6:0] r_sync1;
  logic [6:0] r_sync2;

  // Two-stage synchronizer; resets to blank so nothing is accepted after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
    end else begin
      r_sync1 <= bus.seg_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_filt_in = r_sync2;
`else
  assign w_filt_in = bus.seg_in;
`endif

  logic [6:0] r_sample;
  logic [6:0] r_last;
  logic [3:0] r_cnt;
  logic       w_same;
  logic       w_accept;

  // Acceptance fires on the edge that moves the counter to its final value.
  assign w_same   = (w_filt_in == r_sample);
  assign w_accept = w_same && (r_cnt == CNT_ACC) && (w_filt_in != r_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= SEG_BLANK;
      r_cnt    <= 4'd0;
    end else begin
      r_sample <= w_filt_in;
      if (!w_same) begin
        r_cnt <= 4'd0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  logic [3:0] w_digit;
  logic       w_err;
  logic       w_blank;

  seg_lut u_lut (
    .i_pattern (w_filt_in),
    .o_digit   (w_digit),
    .o_err     (w_err),
    .o_blank   (w_blank)
  );

  seg_state_t r_state;
  seg_state_t w_state_next;
  logic       w_xfer;
  logic       w_valid;

  assign w_xfer = (r_state == ST_PEND) && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_next = w_accept ? ST_PEND : ST_IDLE;
      ST_PEND: w_state_next = (w_xfer && !w_accept) ? ST_IDLE : ST_PEND;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_valid = 1'b0;
      ST_PEND: w_valid = 1'b1;
      default: w_valid = 1'b0;
    endcase
  end

  logic [3:0] r_digit;
  logic       r_err;
  logic       r_blank;
  logic       r_overrun;

  // Result hold; overrun latches only when a pending result is lost untransferred.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit   <= 4'h0;
      r_err     <= 1'b0;
      r_blank   <= 1'b0;
      r_last    <= SEG_BLANK;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_digit <= w_digit;
        r_err   <= w_err;
        r_blank <= w_blank;
        r_last  <= w_filt_in;
      end else begin
        r_digit <= r_digit;
        r_err   <= r_err;
        r_blank <= r_blank;
        r_last  <= r_last;
      end
      if (w_accept && (r_state == ST_PEND) && !bus.out_ready) begin
        r_overrun <= 1'b1;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign bus.out_digit = r_digit;
  assign bus.out_err   = r_err;
  assign bus.out_blank = r_blank;
  assign bus.out_valid = w_valid;
  assign bus.overrun   = r_overrun;

endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..15: consecutive identical samples required before a pattern is accepted.
REQ-002 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port seg_in, input, 7: active-low segment lines; seg_in[0]=s0 (a) .. seg_in[6]=s6 (g); asynchronous to clk.
REQ-005 SHALL have port out_digit, output, 4: decoded hex value of the accepted pattern.
REQ-006 SHALL have port out_err, output, 1: accepted pattern is not a legal glyph.
REQ-007 SHALL have port out_blank, output, 1: accepted pattern is 7'h7F (all segments off).
REQ-008 SHALL have port out_valid, output, 1: out_digit/out_err/out_blank hold a pending result.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts; transfer when out_valid && out_ready.
REQ-010 SHALL have port overrun, output, 1: sticky; a pending result was overwritten.

Function
REQ-011 SHALL decode {s6..s0} as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex).
REQ-012 SHALL decode 7'h7F as out_blank=1, out_err=0, out_digit=0; any other unlisted pattern as out_err=1, out_blank=0, out_digit=0.
REQ-013 SHALL run a stability filter: 4-bit counter cleared when the sample differs from the previous sample, incremented (saturating at STABLE_CYCLES-1) when equal.
REQ-014 SHALL accept a pattern in the cycle the counter reaches STABLE_CYCLES-1, only if it differs from the last accepted pattern; a steady pattern produces exactly one result.
REQ-015 SHALL on acceptance register decode results into out_digit/out_err/out_blank, set out_valid in the next cycle, and record the pattern as last accepted.
REQ-016 SHALL implement FSM IDLE (out_valid=0) and PEND (out_valid=1): IDLE->PEND on acceptance; PEND->IDLE on transfer without acceptance; PEND->PEND otherwise.
REQ-017 SHALL keep outputs stable in PEND until transfer or overwrite.
REQ-018 SHALL on simultaneous transfer and acceptance load the new result, keep out_valid=1, and not set overrun.
REQ-019 SHALL on acceptance in PEND without transfer overwrite the result and set overrun=1 until reset.
REQ-020 SHALL with a held pattern assert out_valid STABLE_CYCLES+2 cycles after seg_in changes (with SEG_DEC_SYNC_EN); STABLE_CYCLES cycles without it.
REQ-021 SHALL restart filtering if seg_in glitches before acceptance, with no result emitted for the glitch value.

Reset
REQ-022 SHALL asynchronously on reset_n=0 clear out_digit=0, out_err=0, out_blank=0, out_valid=0, overrun=0, counter=0, FSM=IDLE.
REQ-023 SHALL reset last-accepted and sample registers to 7'h7F, so a blank display after reset emits nothing.
REQ-024 SHALL discard any in-progress filtering or pending result on reset mid-operation.

Configuration
REQ-025 SHALL with macro SEG_DEC_SYNC_EN defined pass seg_in through a 2-flop synchronizer (reset to 7'h7F) before the filter.
REQ-026 SHALL without SEG_DEC_SYNC_EN sample seg_in directly into the filter; function otherwise identical.

Structure
REQ-027 SHALL place the 16 glyph constants, SEG_BLANK (7'h7F), and FSM state typedef in shared package seg_pkg.
REQ-028 SHALL implement the pattern lookup as combinational sub-module seg_lut (pattern in; digit, err, blank out).

Verification
REQ-029 SHALL test: reset, seg_in=7'h24 held 10 cycles, out_ready=1 -> one out_valid pulse, out_digit=2, out_err=0.
REQ-030 SHALL test: seg_in=7'h40 for 2 cycles then 7'h79 held -> no result for 0; single result out_digit=1.
REQ-031 SHALL test: out_ready=0, seg_in 7'h00 then 7'h18, each held 8 cycles -> out_digit=9 pending, overrun=1.
REQ-032 SHALL test: seg_in=7'h55 held -> out_err=1, out_digit=0; then 7'h7F -> out_blank=1, out_err=0.
REQ-033 SHALL test: transfer in the cycle a new result (7'h0E) is accepted -> out_valid stays 1, out_digit=F, overrun=0.
REQ-034 SHALL test: reset_n pulsed low while PEND -> out_valid=0 and overrun=0 immediately; held 7'h7F after release emits nothing.
